mem_req_arbiter: RTL and testbench

- Parametrised N-channel arbiter between the cache miss ports (i_cache, d_cache, future uncached/prefetch ports) and the single-outstanding AXI interface port.
- Generalises the two-way cache-miss mux to NUM_CH channels with a selectable fixed-priority or round-robin policy.
- Grants are registered and locked for the whole transaction; request fields are latched at grant so the downstream port sees stable values.
- Sits between the caches and axi_interface inside the CPU top.

---
 rtl/mem_req_arbiter.sv | 177 +++++++++++++++++
 tb/tb_mem_req_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: N-channel arbiter between the cache miss ports and the
// single-outstanding AXI interface port. It offers fixed-priority or
// round-robin selection. The grant is registered and held for the whole
// transaction, and the winner's request fields are latched when it is granted.
module mem_req_arbiter #(
   parameter int  NUM_CH  = 2,
   parameter int  ADDR_W  = 32,
   parameter int  DATA_W  = 32,
   parameter int  RR_MODE = 0,
   localparam int GID_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_CH-1:0]        req_access,
   input  logic [NUM_CH-1:0]        req_write,
   input  logic [NUM_CH*ADDR_W-1:0] req_a,
   input  logic [NUM_CH*2-1:0]      req_size,
   input  logic [NUM_CH*4-1:0]      req_sel,
   input  logic [NUM_CH*DATA_W-1:0] req_st_data,
   output logic [NUM_CH-1:0]        req_ready,
   output logic [DATA_W-1:0]        req_data,
   output logic                     mem_access,
   output logic                     mem_write,
   output logic [ADDR_W-1:0]        mem_a,
   output logic [1:0]               mem_size,
   output logic [3:0]               mem_sel,
   output logic [DATA_W-1:0]        mem_st_data,
   input  logic                     mem_ready,
   input  logic [DATA_W-1:0]        mem_data,
   output logic [GID_W-1:0]         grant_id,
   output logic                     busy
);

   typedef enum logic {S_IDLE, S_BUSY} state_t;

   state_t              r_state;
   state_t              w_next_state;

   logic                r_mem_access;
   logic                r_mem_write;
   logic [ADDR_W-1:0]   r_mem_a;
   logic [1:0]          r_mem_size;
   logic [3:0]          r_mem_sel;
   logic [DATA_W-1:0]   r_mem_st_data;
   logic [GID_W-1:0]    r_grant_id;
   logic                r_busy;
   logic [GID_W-1:0]    r_ptr;
   logic [NUM_CH-1:0]   r_mask;

   logic [NUM_CH-1:0]   w_eligible;
   logic                w_found;
   logic [GID_W-1:0]    w_winner;
   logic                w_win_write;
   logic [ADDR_W-1:0]   w_win_a;
   logic [1:0]          w_win_size;
   logic [3:0]          w_win_sel;
   logic [DATA_W-1:0]   w_win_st_data;
   logic [NUM_CH-1:0]   w_grant_onehot;
   logic [GID_W-1:0]    w_next_ptr;

   // Pick the winner. The scan starts at the round-robin pointer in RR mode
   // and at channel 0 in fixed mode, and wraps modulo NUM_CH.
   always_comb begin
      int v_idx;
      // NOTE: every combinational output gets a default first, so that no path
      // through the block can leave a value unassigned and infer a latch.
      w_eligible    = req_access & ~r_mask;
      w_found       = 1'b0;
      w_winner      = '0;
      w_win_write   = 1'b0;
      w_win_a       = '0;
      w_win_size    = '0;
      w_win_sel     = '0;
      w_win_st_data = '0;
      v_idx         = 0;
      for (int k = 0; k < NUM_CH; k++) begin
         v_idx = ((RR_MODE != 0) ? int'(r_ptr) : 0) + k;
         if (v_idx >= NUM_CH) v_idx = v_idx - NUM_CH;
         if (!w_found && w_eligible[v_idx]) begin
            w_found       = 1'b1;
            w_winner      = GID_W'(v_idx);
            w_win_write   = req_write[v_idx];
            w_win_a       = req_a[v_idx*ADDR_W +: ADDR_W];
            w_win_size    = req_size[v_idx*2 +: 2];
            w_win_sel     = req_sel[v_idx*4 +: 4];
            w_win_st_data = req_st_data[v_idx*DATA_W +: DATA_W];
         end
      end
   end

   // Decode the granted channel, and compute the pointer value that follows it.
   always_comb begin
      w_grant_onehot = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (r_grant_id == GID_W'(i)) w_grant_onehot[i] = 1'b1;
      end
      w_next_ptr = (int'(r_grant_id) == NUM_CH - 1) ? '0 : r_grant_id + 1'b1;
   end

   // Next state, plus the completion pulse routed back to the granted channel.
   always_comb begin
      w_next_state = r_state;
      req_ready    = '0;
      case (r_state)
         S_IDLE: if (w_found) w_next_state = S_BUSY;
         S_BUSY: begin
            if (mem_ready) begin
               w_next_state = S_IDLE;
               req_ready    = w_grant_onehot;
            end
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments, so every register
      // samples pre-edge values regardless of statement order.
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next_state;
   end

   // Latch the winner at grant, release on completion, and update the
   // completion mask and the round-robin pointer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mem_access  <= 1'b0;
         r_mem_write   <= 1'b0;
         r_mem_a       <= '0;
         r_mem_size    <= '0;
         r_mem_sel     <= '0;
         r_mem_st_data <= '0;
         r_grant_id    <= '0;
         r_busy        <= 1'b0;
         r_ptr         <= '0;
         r_mask        <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               // The mask only covers the first idle cycle after a completion.
               r_mask <= '0;
               if (w_found) begin
                  r_mem_write   <= w_win_write;
                  r_mem_a       <= w_win_a;
                  r_mem_size    <= w_win_size;
                  r_mem_sel     <= w_win_sel;
                  r_mem_st_data <= w_win_st_data;
                  r_grant_id    <= w_winner;
                  r_mem_access  <= 1'b1;
                  r_busy        <= 1'b1;
               end
            end
            S_BUSY: begin
               if (mem_ready) begin
                  r_mem_access <= 1'b0;
                  r_busy       <= 1'b0;
                  r_mask       <= w_grant_onehot;
                  if (RR_MODE != 0) r_ptr <= w_next_ptr;
               end
            end
            default: ;
         endcase
      end
   end

   assign req_data    = mem_data;
   assign mem_access  = r_mem_access;
   assign mem_write   = r_mem_write;
   assign mem_a       = r_mem_a;
   assign mem_size    = r_mem_size;
   assign mem_sel     = r_mem_sel;
   assign mem_st_data = r_mem_st_data;
   assign grant_id    = r_grant_id;
   assign busy        = r_busy;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb_mem_req_arbiter: directed bench for mem_req_arbiter. Instance a is
// 2-channel fixed-priority and instance b is 3-channel round-robin.
module tb_mem_req_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   // Instance a: NUM_CH=2, RR_MODE=0
   logic [1:0]  a_req_access = '0, a_req_write = '0;
   logic [63:0] a_req_a = '0, a_req_st_data = '0;
   logic [3:0]  a_req_size = '0;
   logic [7:0]  a_req_sel = '0;
   logic [1:0]  a_req_ready;
   logic [31:0] a_req_data;
   logic        a_mem_access, a_mem_write, a_busy;
   logic [31:0] a_mem_a, a_mem_st_data;
   logic [1:0]  a_mem_size;
   logic [3:0]  a_mem_sel;
   logic        a_mem_ready = 1'b0;
   logic [31:0] a_mem_data = '0;
   logic [0:0]  a_grant_id;

   // Instance b: NUM_CH=3, RR_MODE=1
   logic [2:0]  b_req_access = '0, b_req_write = '0;
   logic [95:0] b_req_a = '0, b_req_st_data = '0;
   logic [5:0]  b_req_size = '0;
   logic [11:0] b_req_sel = '0;
   logic [2:0]  b_req_ready;
   logic [31:0] b_req_data;
   logic        b_mem_access, b_mem_write, b_busy;
   logic [31:0] b_mem_a, b_mem_st_data;
   logic [1:0]  b_mem_size;
   logic [3:0]  b_mem_sel;
   logic        b_mem_ready = 1'b0;
   logic [31:0] b_mem_data = '0;
   logic [1:0]  b_grant_id;

   mem_req_arbiter #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32), .RR_MODE(0)) dut_a (
      .clk(clk), .rst(rst),
      .req_access(a_req_access), .req_write(a_req_write), .req_a(a_req_a),
      .req_size(a_req_size), .req_sel(a_req_sel), .req_st_data(a_req_st_data),
      .req_ready(a_req_ready), .req_data(a_req_data),
      .mem_access(a_mem_access), .mem_write(a_mem_write), .mem_a(a_mem_a),
      .mem_size(a_mem_size), .mem_sel(a_mem_sel), .mem_st_data(a_mem_st_data),
      .mem_ready(a_mem_ready), .mem_data(a_mem_data),
      .grant_id(a_grant_id), .busy(a_busy)
   );

   mem_req_arbiter #(.NUM_CH(3), .ADDR_W(32), .DATA_W(32), .RR_MODE(1)) dut_b (
      .clk(clk), .rst(rst),
      .req_access(b_req_access), .req_write(b_req_write), .req_a(b_req_a),
      .req_size(b_req_size), .req_sel(b_req_sel), .req_st_data(b_req_st_data),
      .req_ready(b_req_ready), .req_data(b_req_data),
      .mem_access(b_mem_access), .mem_write(b_mem_write), .mem_a(b_mem_a),
      .mem_size(b_mem_size), .mem_sel(b_mem_sel), .mem_st_data(b_mem_st_data),
      .mem_ready(b_mem_ready), .mem_data(b_mem_data),
      .grant_id(b_grant_id), .busy(b_busy)
   );

   always #5 clk = ~clk;

   // Watchdog against a hung run.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int exp_order [4];
      exp_order = '{0, 1, 2, 0};

      rst = 1'b1;
      #12;
      check("rst_mem_access", 64'(a_mem_access), 64'd0);
      check("rst_busy",       64'(a_busy),       64'd0);
      check("rst_grant_id",   64'(a_grant_id),   64'd0);
      check("rst_mem_a",      64'(a_mem_a),      64'd0);
      check("rst_req_ready",  64'(a_req_ready),  64'd0);
      check("rst_b_access",   64'(b_mem_access), 64'd0);
      rst = 1'b0;
      step();

      // ---- Single read on ch1 ----
      a_req_access       = 2'b10;
      a_req_write        = 2'b00;
      a_req_a[63:32]     = 32'h1FC0_0010;
      a_req_size[3:2]    = 2'd2;
      #1;
      check("rd_pre_access", 64'(a_mem_access), 64'd0);
      step();
      check("rd_access",   64'(a_mem_access), 64'd1);
      check("rd_busy",     64'(a_busy),       64'd1);
      check("rd_grant",    64'(a_grant_id),   64'd1);
      check("rd_mem_a",    64'(a_mem_a),      64'h1FC0_0010);
      check("rd_mem_size", 64'(a_mem_size),   64'd2);
      check("rd_mem_wr",   64'(a_mem_write),  64'd0);
      step();
      check("rd_wait_ready", 64'(a_req_ready), 64'd0);
      step();
      a_mem_ready = 1'b1;
      a_mem_data  = 32'hDEADBEEF;
      #1;
      check("rd_req_ready", 64'(a_req_ready), 64'b10);
      check("rd_req_data",  64'(a_req_data),  64'hDEADBEEF);
      step();
      a_mem_ready  = 1'b0;
      a_req_access = 2'b00;
      #1;
      check("rd_done_busy",   64'(a_busy),       64'd0);
      check("rd_done_access", 64'(a_mem_access), 64'd0);
      check("rd_done_ready",  64'(a_req_ready),  64'd0);
      check("rd_grant_hold",  64'(a_grant_id),   64'd1);

      // mem_ready while idle must not produce req_ready or a grant.
      a_mem_ready = 1'b1;
      #1;
      check("idle_ready", 64'(a_req_ready), 64'd0);
      step();
      check("idle_busy", 64'(a_busy), 64'd0);
      a_mem_ready = 1'b0;
      step();

      // ---- Fixed priority + store latching ----
      a_req_access        = 2'b11;
      a_req_write         = 2'b01;
      a_req_a             = {32'h0000_0200, 32'h0000_0100};
      a_req_sel           = {4'b1111, 4'b0011};
      a_req_st_data       = {32'h0, 32'h0000_1234};
      a_req_size          = {2'd2, 2'd1};
      step();
      check("fp_grant0",  64'(a_grant_id),    64'd0);
      check("st_mem_a",   64'(a_mem_a),       64'h100);
      check("st_mem_sel", 64'(a_mem_sel),     64'b0011);
      check("st_mem_std", 64'(a_mem_st_data), 64'h1234);
      check("st_mem_wr",  64'(a_mem_write),   64'd1);
      a_req_a[31:0]       = 32'h0000_0ABC;
      a_req_sel[3:0]      = 4'b1111;
      a_req_st_data[31:0] = 32'h0000_5555;
      a_req_write         = 2'b00;
      step();
      step();
      check("st_hold_a",   64'(a_mem_a),       64'h100);
      check("st_hold_sel", 64'(a_mem_sel),     64'b0011);
      check("st_hold_std", 64'(a_mem_st_data), 64'h1234);
      check("st_hold_wr",  64'(a_mem_write),   64'd1);
      a_mem_ready = 1'b1;
      #1;
      check("fp_ready0", 64'(a_req_ready), 64'b01);
      step();
      a_mem_ready  = 1'b0;
      a_req_access = 2'b10;
      #1;
      check("fp_gap", 64'(a_mem_access), 64'd0);
      step();
      check("fp_grant1",  64'(a_grant_id),  64'd1);
      check("fp_access1", 64'(a_mem_access), 64'd1);
      check("fp_mem_a1",  64'(a_mem_a),     64'h200);
      a_mem_ready = 1'b1;
      #1;
      check("fp_ready1", 64'(a_req_ready), 64'b10);
      step();
      a_mem_ready  = 1'b0;
      a_req_access = 2'b00;
      step();

      // ---- Late strobe: ch0 held one extra cycle, then dropped ----
      a_req_access  = 2'b01;
      a_req_a[31:0] = 32'h0000_0300;
      step();
      check("ls_grant", 64'(a_mem_access), 64'd1);
      a_mem_ready = 1'b1;
      step();
      a_mem_ready = 1'b0;
      #1;
      check("ls_masked_idle", 64'(a_mem_access), 64'd0);
      step();
      a_req_access = 2'b00;
      #1;
      check("ls_no_regrant", 64'(a_mem_access), 64'd0);
      step();
      check("ls_still_idle", 64'(a_busy), 64'd0);

      // ---- Late strobe: ch0 still high after the masked cycle ----
      a_req_access = 2'b01;
      step();
      a_mem_ready = 1'b1;
      step();
      a_mem_ready = 1'b0;
      step();
      check("ls2_masked", 64'(a_mem_access), 64'd0);
      step();
      check("ls2_regrant", 64'(a_mem_access), 64'd1);
      check("ls2_grant_id", 64'(a_grant_id), 64'd0);
      a_mem_ready = 1'b1;
      step();
      a_mem_ready  = 1'b0;
      a_req_access = 2'b00;
      step();
      check("ls2_one_grant", 64'(a_mem_access), 64'd0);
      step();
      check("ls2_idle", 64'(a_busy), 64'd0);

      // ---- Reset while busy ----
      a_req_access = 2'b10;
      step();
      check("rb_busy", 64'(a_busy), 64'd1);
      step();
      #2;
      rst         = 1'b1;
      a_mem_ready = 1'b1;
      #1;
      check("rb_access", 64'(a_mem_access), 64'd0);
      check("rb_busy0",  64'(a_busy),       64'd0);
      check("rb_grant",  64'(a_grant_id),   64'd0);
      check("rb_ready",  64'(a_req_ready),  64'd0);
      step();
      rst         = 1'b0;
      a_mem_ready = 1'b0;
      step();
      check("rb_resume",       64'(a_mem_access), 64'd1);
      check("rb_resume_grant", 64'(a_grant_id),   64'd1);
      a_mem_ready = 1'b1;
      #1;
      check("rb_resume_ready", 64'(a_req_ready), 64'b10);
      step();
      a_mem_ready  = 1'b0;
      a_req_access = 2'b00;
      step();

      // ---- Round-robin, three channels held continuously ----
      b_req_access = 3'b111;
      b_req_a      = {32'h0000_0C00, 32'h0000_0B00, 32'h0000_0A00};
      step();
      for (int g = 0; g < 4; g++) begin
         check("rr_grant",  64'(b_grant_id),   64'(exp_order[g]));
         check("rr_access", 64'(b_mem_access), 64'd1);
         b_mem_ready = 1'b1;
         #1;
         check("rr_ready", 64'(b_req_ready), 64'(3'b001 << exp_order[g]));
         step();
         b_mem_ready = 1'b0;
         #1;
         check("rr_gap", 64'(b_mem_access), 64'd0);
         step();
      end
      check("rr_mem_a_wrap", 64'(b_mem_a), 64'h0000_0B00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
